eth_udp_tx_arbiter: RTL
=======================

Name: eth_udp_tx_arbiter

Overview:
- Shares the single UDP transmit path (udp tx_start_en/tx_data/tx_byte_num/tx_req/tx_done) between two requesters: ch0 = waveform stream, ch1 = command/response.
- Round-robin arbitration, one packet per grant; issues the start pulse, muxes data, routes read requests, waits for completion, enforces inter-packet gap.
- Sits in the gmii_tx_clk domain between the DSO packetisers and the udp block.

Parameters:
- IFG_CYC, 12, idle cycles between tx_done and the next grant (0 = none).
- TIMEOUT_CYC, 65535, BUSY cycles without tx_done before abort (only with macro).

Ports:
- gmii_tx_clk  in  1  clock (GMII transmit clock)
- rst_n  in  1  asynchronous active-low reset
- ch0_req  in  1  ch0 packet request, level
- ch0_byte_num  in  16  ch0 payload bytes, stable while ch0_req high
- ch0_data  in  32  ch0 payload word
- ch0_grant  out  1  ch0 owns the path
- ch0_data_req  out  1  ch0 word read strobe
- ch0_done  out  1  ch0 packet finished, 1-cycle pulse
- ch1_req, ch1_byte_num, ch1_data, ch1_grant, ch1_data_req, ch1_done: same as ch0
- tx_start_en  out  1  start pulse to udp
- tx_byte_num  out  16  length to udp
- tx_data  out  32  data to udp
- tx_req  in  1  udp word request
- tx_done  in  1  udp packet sent, pulse
- busy  out  1  state != IDLE
- timeout_err  out  1  abort pulse

Behaviour:
- Clock/reset: one clock gmii_tx_clk; rst_n asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; last_grant = 1, so ch0 wins the first tie; counters 0.
- States: IDLE, START, BUSY, GAP.
- IDLE, winner selection:
  - Only one req high: that channel wins.
  - Both high: the channel != last_grant wins.
  - Neither high: stay in IDLE.
- IDLE, at the edge after winner selection:
  - chX_grant <= 1, last_grant <= X, tx_byte_num <= chX_byte_num.
  - Go to START.
  - Exception: chX_byte_num == 0. Then no START is issued; chX_done pulses next cycle, last_grant <= X, return to IDLE, no gap.
- START: exactly one cycle; tx_start_en = 1 (registered); tx_done ignored; go to BUSY.
- BUSY:
  - tx_data = granted channel's data (combinational mux); 0 when no grant.
  - chX_data_req = tx_req & chX_grant (combinational, same cycle); the other channel's data_req = 0.
  - On tx_done: chX_done <= 1 for one cycle, grant <= 0, gap counter <= IFG_CYC. Go to GAP, or to IDLE if IFG_CYC == 0.
- GAP: count down to 0, then IDLE; requests are not sampled during GAP.
- Request rules:
  - Requester must hold req and byte_num until its done pulse. Deassertion mid-packet is ignored; the packet completes and done still pulses.
  - req still high in IDLE after done counts as a new request; round-robin gives the other channel priority if it is requesting.
- Latency: req rising in IDLE cycle N gives grant from cycle N+1 and tx_start_en in cycle N+1. Minimum spacing from done to next start = IFG_CYC + 2 cycles.
- tx_byte_num holds its value until the next grant.
- busy = (state != IDLE), registered with state.
- Reset asserted mid-operation: everything returns to reset values immediately; no done pulse. The udp block is reset by the same rst_n.

Optional Feature:
- Macro: ETH_TX_ARB_TIMEOUT_EN.
- With macro:
  - 16-bit watchdog cleared on entering BUSY, increments each BUSY cycle.
  - If it reaches TIMEOUT_CYC without tx_done: chX_done and timeout_err pulse together for one cycle, grant <= 0, enter GAP.
  - tx_done in the same cycle as expiry counts as normal completion; no timeout_err.
- Without macro: no watchdog; BUSY waits indefinitely; timeout_err tied to 0.

Test Plan:
- ch0_req with byte_num=64, IFG_CYC=12 -> grant and tx_start_en one cycle after req; tx_byte_num=64; ch0_data_req mirrors tx_req; ch0_done one cycle after tx_done; 12 GAP cycles; busy low after.
- ch0 and ch1 req in the same cycle after reset -> ch0 served first, then ch1 after the gap; ch1 sees no data_req during ch0's packet.
- Both held high across 4 packets -> grant order ch0, ch1, ch0, ch1.
- ch1_byte_num=0 -> ch1_done pulses one cycle after grant; no tx_start_en; next request accepted immediately with no gap.
- With ETH_TX_ARB_TIMEOUT_EN, TIMEOUT_CYC=100, tx_done never sent -> timeout_err and ch0_done at BUSY cycle 100; arbiter back to IDLE after IFG_CYC cycles.
- rst_n asserted mid-BUSY -> all outputs 0 asynchronously, no done pulse; after release, ch0 wins the next tie.

Source files
------------

// File: rtl/eth_udp_tx_arbiter.sv
// Round-robin arbiter sharing one UDP transmit path between a waveform stream (ch0) and a command channel (ch1).
// Optional BUSY watchdog enabled by defining ETH_TX_ARB_TIMEOUT_EN.
module eth_udp_tx_arbiter #(
    parameter int IFG_CYC     = 12,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic        gmii_tx_clk,
    input  logic        rst_n,
    input  logic        ch0_req,
    input  logic [15:0] ch0_byte_num,
    input  logic [31:0] ch0_data,
    output logic        ch0_grant,
    output logic        ch0_data_req,
    output logic        ch0_done,
    input  logic        ch1_req,
    input  logic [15:0] ch1_byte_num,
    input  logic [31:0] ch1_data,
    output logic        ch1_grant,
    output logic        ch1_data_req,
    output logic        ch1_done,
    output logic        tx_start_en,
    output logic [15:0] tx_byte_num,
    output logic [31:0] tx_data,
    input  logic        tx_req,
    input  logic        tx_done,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, START, BUSY, GAP} state_t;

    state_t      state, state_nxt;
    logic        last_grant, last_grant_nxt;
    logic [15:0] gap_cnt, gap_cnt_nxt;
    logic        grant0_nxt, grant1_nxt, done0_nxt, done1_nxt, start_nxt;
    logic [15:0] byte_num_nxt;
    logic        pick1;
    logic [15:0] pick_bytes;
    logic        finish;
    logic        abort;

`ifdef ETH_TX_ARB_TIMEOUT_EN
    logic [15:0] wdog, wdog_nxt;
    logic        terr_nxt;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYC;
    assign timeout_err    = 1'b0;
`endif

    // Handshake: a requester raises chX_req (level) with chX_byte_num stable and keeps
    // both until chX_done; while granted, each tx_req cycle consumes chX_data and
    // is echoed back the same cycle as chX_data_req.
    assign ch0_data_req = tx_req & ch0_grant;
    assign ch1_data_req = tx_req & ch1_grant;
    assign tx_data      = ch0_grant ? ch0_data : (ch1_grant ? ch1_data : 32'd0);

    // Tie-break favours the channel that was not served last.
    assign pick1      = (ch0_req && ch1_req) ? ~last_grant : ch1_req;
    assign pick_bytes = pick1 ? ch1_byte_num : ch0_byte_num;

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        gap_cnt_nxt    = gap_cnt;
        grant0_nxt     = ch0_grant;
        grant1_nxt     = ch1_grant;
        done0_nxt      = 1'b0;
        done1_nxt      = 1'b0;
        start_nxt      = 1'b0;
        byte_num_nxt   = tx_byte_num;
        finish         = 1'b0;
        abort          = 1'b0;
`ifdef ETH_TX_ARB_TIMEOUT_EN
        wdog_nxt       = wdog;
        terr_nxt       = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (ch0_req || ch1_req) begin
                    last_grant_nxt = pick1;
                    if (pick_bytes == 16'd0) begin
                        // Empty packet: acknowledge without touching the udp block.
                        done0_nxt = ~pick1;
                        done1_nxt = pick1;
                    end else begin
                        grant0_nxt   = ~pick1;
                        grant1_nxt   = pick1;
                        byte_num_nxt = pick_bytes;
                        start_nxt    = 1'b1;
                        state_nxt    = START;
                    end
                end
            end
            START: begin
                state_nxt = BUSY;
`ifdef ETH_TX_ARB_TIMEOUT_EN
                wdog_nxt  = 16'd0;
`endif
            end
            BUSY: begin
                if (tx_done) begin
                    finish = 1'b1;
                end else begin
`ifdef ETH_TX_ARB_TIMEOUT_EN
                    if (wdog == 16'(TIMEOUT_CYC - 1)) begin
                        finish   = 1'b1;
                        abort    = 1'b1;
                        terr_nxt = 1'b1;
                    end else begin
                        wdog_nxt = wdog + 16'd1;
                    end
`endif
                end
                if (finish) begin
                    done0_nxt   = ch0_grant;
                    done1_nxt   = ch1_grant;
                    grant0_nxt  = 1'b0;
                    grant1_nxt  = 1'b0;
                    gap_cnt_nxt = 16'(IFG_CYC);
                    state_nxt   = (IFG_CYC == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                gap_cnt_nxt = gap_cnt - 16'd1;
                if (gap_cnt <= 16'd1) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            gap_cnt     <= 16'd0;
            ch0_grant   <= 1'b0;
            ch1_grant   <= 1'b0;
            ch0_done    <= 1'b0;
            ch1_done    <= 1'b0;
            tx_start_en <= 1'b0;
            tx_byte_num <= 16'd0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            last_grant  <= last_grant_nxt;
            gap_cnt     <= gap_cnt_nxt;
            ch0_grant   <= grant0_nxt;
            ch1_grant   <= grant1_nxt;
            ch0_done    <= done0_nxt;
            ch1_done    <= done1_nxt;
            tx_start_en <= start_nxt;
            tx_byte_num <= byte_num_nxt;
            busy        <= (state_nxt != IDLE);
        end
    end

`ifdef ETH_TX_ARB_TIMEOUT_EN
    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog        <= 16'd0;
            timeout_err <= 1'b0;
        end else begin
            wdog        <= wdog_nxt;
            timeout_err <= terr_nxt;
        end
    end
`else
    logic unused_abort;
    assign unused_abort = abort;
`endif

endmodule
